// File: rtl/count_load_seq.sv
// Load sequencer for a loadable counter: queues start values, issues one
// load per run, waits for terminal count. Option: COUNT_LOAD_SEQ_WRAPS_EN.
module count_load_seq #(
  parameter int                CNT_W = 4,
  parameter int                DEPTH = 4,
  parameter logic [CNT_W-1:0]  TERM  = {CNT_W{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  input  logic [CNT_W-1:0]           req_val_i,
  output logic                       req_ready_o,
  input  logic [CNT_W-1:0]           count_i,
  output logic                       load_o,
  output logic [CNT_W-1:0]           load_val_o,
  output logic                       busy_o,
  output logic                       done_o,
`ifdef COUNT_LOAD_SEQ_WRAPS_EN
  output logic [7:0]                 wraps_o,
`endif
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nxt;
  logic [CNT_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [LW-1:0]      r_level;
  logic [CNT_W-1:0]   r_load_val;
  logic               r_done;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_latch;
  logic               w_done_nxt;
  logic               w_run_end;

  assign w_full      = (r_level == LW'(DEPTH));
  assign req_ready_o = !w_full;
  assign w_push      = req_valid_i && !w_full;
  assign w_pop       = (r_state == S_LOAD);
  assign w_run_end   = (r_state == S_RUN) && (count_i == TERM);

  assign load_o      = (r_state == S_LOAD);
  assign load_val_o  = r_load_val;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign level_o     = r_level;

  // FIFO storage; contents are don't-care while not counted by level
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= req_val_i;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Next state; head is captured whenever a load is about to start
  always_comb begin
    w_nxt      = r_state;
    w_latch    = 1'b0;
    w_done_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_nxt   = S_LOAD;
          w_latch = 1'b1;
        end
      end
      S_LOAD: begin
        w_nxt = S_RUN;
      end
      S_RUN: begin
        if (count_i == TERM) begin
          if (r_level != '0) begin
            w_nxt   = S_LOAD;
            w_latch = 1'b1;
          end else begin
            w_nxt      = S_IDLE;
            w_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  // State, load value and done pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_load_val <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_done  <= w_done_nxt;
      if (w_latch) r_load_val <= r_mem[r_rp];
    end
  end

`ifdef COUNT_LOAD_SEQ_WRAPS_EN
  logic [7:0] r_wraps;
  assign wraps_o = r_wraps;

  // Completed-run counter, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wraps <= '0;
    end else if (w_run_end && (r_wraps != 8'hFF)) begin
      r_wraps <= r_wraps + 8'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_run_end;
`endif

endmodule

// File: tb/tb_count_load_seq.sv
// Randomised bench for count_load_seq against a queue-based
// reference model with a behavioural counter in the loop.
module tb_count_load_seq;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid_i = 1'b0;
  logic [3:0] req_val_i = '0;
  logic [3:0] count_i = '0;
  logic       req_ready_o;
  logic       load_o;
  logic [3:0] load_val_o;
  logic       busy_o;
  logic       done_o;
  logic [2:0] level_o;
`ifdef COUNT_LOAD_SEQ_WRAPS_EN
  logic [7:0] wraps_o;
`endif

  count_load_seq dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_val_i   (req_val_i),
    .req_ready_o (req_ready_o),
    .count_i     (count_i),
    .load_o      (load_o),
    .load_val_o  (load_val_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
`ifdef COUNT_LOAD_SEQ_WRAPS_EN
    .wraps_o     (wraps_o),
`endif
    .level_o     (level_o)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference: queue of accepted-but-unissued values plus run phase
  int m_q[$];
  bit m_load;
  bit m_run;
  bit m_done;
  int m_val;
  int m_wraps;
  int m_cnt;
  bit hold;
  int n_done;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic mreset();
    m_q.delete();
    m_load  = 0;
    m_run   = 0;
    m_done  = 0;
    m_val   = 0;
    m_wraps = 0;
    m_cnt   = 0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".load"},  32'(load_o),      32'(m_load));
    chk({ph, ".val"},   32'(load_val_o),  32'(m_val));
    chk({ph, ".busy"},  32'(busy_o),      32'(m_load || m_run));
    chk({ph, ".done"},  32'(done_o),      32'(m_done));
    chk({ph, ".level"}, 32'(level_o),     32'(m_q.size()));
    chk({ph, ".ready"}, 32'(req_ready_o), 32'(m_q.size() < D));
`ifdef COUNT_LOAD_SEQ_WRAPS_EN
    chk({ph, ".wraps"}, 32'(wraps_o),     32'(m_wraps));
`endif
  endtask

  // One clock: advance model over the edge, then check at negedge
  task automatic tick();
    bit acc;
    int c;
    int ncnt;
    c   = int'(count_i);
    acc = req_valid_i && (m_q.size() < D);
    if (hold)        ncnt = 0;
    else if (m_load) ncnt = m_val;
    else             ncnt = (m_cnt + 1) % 16;
    m_done = 0;
    if (m_load) begin
      m_load = 0;
      m_run  = 1;
      void'(m_q.pop_front());
    end else if (m_run) begin
      if (c == 15) begin
        if (m_wraps < 255) m_wraps++;
        m_run = 0;
        if (m_q.size() != 0) begin
          m_load = 1;
          m_val  = m_q[0];
        end else begin
          m_done = 1;
        end
      end
    end else if (m_q.size() != 0) begin
      m_load = 1;
      m_val  = m_q[0];
    end
    if (acc) m_q.push_back(int'(req_val_i));
    m_cnt = ncnt;
    @(posedge clk);
    @(negedge clk);
    count_i = 4'(m_cnt);
    if (done_o) n_done++;
    check_all("cyc");
  endtask

  task automatic push(input logic [3:0] v);
    req_valid_i = 1'b1;
    req_val_i   = v;
    tick();
    req_valid_i = 1'b0;
  endtask

  initial begin
    hold   = 0;
    n_done = 0;
    mreset();
    // T1 reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all("t1");
    // T2 single run from 3
    push(4'h3);
    repeat (20) tick();
    chk("t2.ndone", 32'(n_done), 32'd1);
    // T3 three queued runs
    push(4'h0);
    push(4'h3);
    push(4'h6);
    repeat (60) tick();
    chk("t3.ndone", 32'(n_done), 32'd2);
    // T4 fill FIFO while a run is stalled
    hold = 1;
    count_i = '0;
    m_cnt = 0;
    push(4'h5);
    repeat (3) tick();
    push(4'h1);
    push(4'h2);
    push(4'h3);
    push(4'h4);
    chk("t4.full_rdy", 32'(req_ready_o), 32'd0);
    chk("t4.full_lvl", 32'(level_o), 32'd4);
    push(4'h9);
    chk("t4.rej_lvl", 32'(level_o), 32'd4);
    hold = 0;
    repeat (20) tick();
    chk("t4.rdy_back", 32'(req_ready_o), 32'd1);
    repeat (80) tick();
    // T5 start value equals terminal count
    push(4'hF);
    repeat (6) tick();
    // T6 reset mid-run with two queued
    hold = 1;
    count_i = '0;
    m_cnt = 0;
    push(4'h7);
    repeat (3) tick();
    push(4'h1);
    push(4'h2);
    chk("t6.pre_lvl", 32'(level_o), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t6.rst_load",  32'(load_o),  32'd0);
    chk("t6.rst_level", 32'(level_o), 32'd0);
    chk("t6.rst_busy",  32'(busy_o),  32'd0);
    mreset();
    hold = 0;
    count_i = '0;
    @(negedge clk);
    rst = 1'b0;
    check_all("t6");
    repeat (30) tick();
    // Random traffic
    repeat (900) begin
      req_valid_i = ($urandom_range(0, 2) == 0);
      req_val_i   = 4'($urandom);
      tick();
    end
    req_valid_i = 1'b0;
    repeat (120) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
